// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory handshake, buffered instruction
// toward decode, and the redirect/halt feedback from the control unit.
//   master : the fetch unit itself (drives imemREN/imemaddr/instr/npc/ivalid/fetch_cnt)
//   slave  : the environment (memory + control unit)
interface fetch_unit_if;
  logic        ihit;
  logic [31:0] iload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] instr;
  logic [31:0] npc;
  logic        ivalid;
  logic        stall;
  logic [2:0]  pcsrc;
  logic        redirect;
  logic [31:0] branch_addr;
  logic [25:0] jump_addr;
  logic [31:0] jr_addr;
  logic        halt;
  logic [15:0] fetch_cnt;

  modport master (
    input  ihit, iload, stall, pcsrc, redirect, branch_addr, jump_addr, jr_addr, halt,
    output imemREN, imemaddr, instr, npc, ivalid, fetch_cnt
  );

  modport slave (
    output ihit, iload, stall, pcsrc, redirect, branch_addr, jump_addr, jr_addr, halt,
    input  imemREN, imemaddr, instr, npc, ivalid, fetch_cnt
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit with a one-entry instruction buffer.
// Ports:
//   CLK  - rising-edge clock
//   nRST - asynchronous active-low reset
//   bus  - fetch_unit_if.master: memory request/response, buffered instr/npc/ivalid toward
//          decode, stall/redirect/halt feedback, and the accepted-fetch counter.
// A fetched word is held in instr/npc until decode consumes it; a redirect or halt
// decoded from the buffered instruction takes effect on the consuming edge and drops
// any memory response arriving in the same cycle.
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input logic       CLK,
  input logic       nRST,
  fetch_unit_if.master bus
);

  localparam logic [0:0] FETCH  = 1'b0;
  localparam logic [0:0] HALTED = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] npc_q, npc_d;
  logic        ivalid_q, ivalid_d;
  logic [15:0] cnt_q, cnt_d;

  logic        ren;
  logic        consume;
  logic        pcsrc_ok;
  logic        redirect_eff;
  logic        halt_eff;
  logic        accept;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_target;

  // A stalled, still-valid buffer blocks new requests so the held word is not lost.
  assign ren          = (state_q == FETCH) && !(ivalid_q && bus.stall);
  assign consume      = ivalid_q && !bus.stall;
  assign pcsrc_ok     = (bus.pcsrc == 3'd1) || (bus.pcsrc == 3'd2) || (bus.pcsrc == 3'd3);
  assign redirect_eff = bus.redirect && consume && pcsrc_ok;
  assign halt_eff     = bus.halt && consume;
  assign accept       = bus.ihit && ren && !redirect_eff && !halt_eff;
  assign pc_plus4     = pc_q + 32'd4;

  // Jump target takes its upper nibble from the buffered instruction's npc.
  always_comb begin
    redirect_target = bus.jr_addr;
    case (bus.pcsrc)
      3'd1:    redirect_target = bus.branch_addr;
      3'd2:    redirect_target = {npc_q[31:28], bus.jump_addr, 2'b00};
      default: redirect_target = bus.jr_addr;
    endcase
  end

  // Priority: halt, then redirect, then accept, then plain consume.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    npc_d    = npc_q;
    ivalid_d = ivalid_q;
    cnt_d    = cnt_q;
    if (state_q == FETCH) begin
      if (halt_eff) begin
        state_d  = HALTED;
        ivalid_d = 1'b0;
      end else if (redirect_eff) begin
        pc_d     = redirect_target;
        ivalid_d = 1'b0;
      end else if (accept) begin
        instr_d  = bus.iload;
        npc_d    = pc_plus4;
        pc_d     = pc_plus4;
        ivalid_d = 1'b1;
        cnt_d    = cnt_q + 16'd1;
      end else if (consume) begin
        ivalid_d = 1'b0;
      end
    end else begin
      ivalid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= FETCH;
      pc_q     <= PC_INIT;
      instr_q  <= 32'h0;
      npc_q    <= 32'h0;
      ivalid_q <= 1'b0;
      cnt_q    <= 16'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      npc_q    <= npc_d;
      ivalid_q <= ivalid_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.imemREN   = ren;
  assign bus.imemaddr  = {pc_q[31:2], 2'b00};
  assign bus.instr     = instr_q;
  assign bus.npc       = npc_q;
  assign bus.ivalid    = ivalid_q;
  assign bus.fetch_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic CLK;
  logic nRST;

  fetch_unit_if b ();
  fetch_unit_if bw ();

  fetch_unit #(.PC_INIT(32'h0000_0000)) dut (.CLK(CLK), .nRST(nRST), .bus(b));
  fetch_unit #(.PC_INIT(32'hFFFF_FFFC)) dut_w (.CLK(CLK), .nRST(nRST), .bus(bw));

  int n_cmp;
  int n_bad;

  // Reference model: architectural view of the fetch stage.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_npc;
  logic        m_valid;
  logic        m_halted;
  logic [15:0] m_cnt;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_npc = 32'h0;
    m_valid = 1'b0; m_halted = 1'b0; m_cnt = 16'h0;
  endfunction

  function automatic void model_step();
    logic take;
    take = m_valid && !b.stall;
    if (m_halted) return;
    if (take && b.halt) begin
      m_halted = 1'b1;
      m_valid  = 1'b0;
    end else if (take && b.redirect && b.pcsrc >= 3'd1 && b.pcsrc <= 3'd3) begin
      if (b.pcsrc == 3'd1) m_pc = b.branch_addr;
      else if (b.pcsrc == 3'd2) m_pc = (m_npc & 32'hF000_0000) | ({6'd0, b.jump_addr} << 2);
      else m_pc = b.jr_addr;
      m_valid = 1'b0;
    end else if (b.ihit && !(m_valid && b.stall)) begin
      m_instr = b.iload;
      m_pc    = m_pc + 32'd4;
      m_npc   = m_pc;
      m_valid = 1'b1;
      m_cnt   = m_cnt + 16'd1;
    end else if (take) begin
      m_valid = 1'b0;
    end
  endfunction

  task automatic drive(input logic ihit, input logic [31:0] iload, input logic stall,
                       input logic redirect, input logic [2:0] pcsrc, input logic halt);
    b.ihit = ihit; b.iload = iload; b.stall = stall;
    b.redirect = redirect; b.pcsrc = pcsrc; b.halt = halt;
  endtask

  task automatic step();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic zero_inputs();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b0);
    b.branch_addr = 32'h0; b.jump_addr = 26'h0; b.jr_addr = 32'h0;
    bw.ihit = 1'b0; bw.iload = 32'h0; bw.stall = 1'b0; bw.redirect = 1'b0;
    bw.pcsrc = 3'd0; bw.halt = 1'b0; bw.branch_addr = 32'h0; bw.jump_addr = 26'h0;
    bw.jr_addr = 32'h0;
  endtask

  task automatic do_reset();
    zero_inputs();
    @(negedge CLK);
    nRST = 1'b0;
    #2;
    nRST = 1'b1;
    model_reset();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    zero_inputs();
    @(negedge CLK);
    #1 nRST = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (b.imemREN !== 1'b1) begin n_bad++; $display("FAIL reset_ren: got %0b want 1", b.imemREN); end
    n_cmp++; if (b.imemaddr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", b.imemaddr); end
    n_cmp++; if (b.ivalid !== 1'b0) begin n_bad++; $display("FAIL reset_ivalid: got %0b want 0", b.ivalid); end
    n_cmp++; if (b.instr !== 32'h0 || b.npc !== 32'h0) begin n_bad++; $display("FAIL reset_instr_npc: got %h/%h want 0/0", b.instr, b.npc); end
    n_cmp++; if (b.fetch_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", b.fetch_cnt); end
    n_cmp++; if (bw.imemaddr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL reset_addr_w: got %h want fffffffc", bw.imemaddr); end
    // An ihit during reset must be ignored.
    b.ihit = 1'b1; b.iload = 32'hDEAD_BEEF;
    @(posedge CLK);
    #1;
    n_cmp++; if (b.ivalid !== 1'b0 || b.fetch_cnt !== 16'h0 || b.imemaddr !== 32'h0) begin
      n_bad++; $display("FAIL reset_ihit_ignored: got v=%0b cnt=%0d addr=%h want 0/0/0", b.ivalid, b.fetch_cnt, b.imemaddr);
    end
    b.ihit = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_sequential();
    logic [31:0] w [3];
    w[0] = 32'hAAAA_0001; w[1] = 32'hBBBB_0002; w[2] = 32'hCCCC_0003;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, w[i], 1'b0, 1'b0, 3'd0, 1'b0);
      n_cmp++; if (b.imemaddr !== 32'(4 * i)) begin n_bad++; $display("FAIL seq_addr%0d: got %h want %h", i, b.imemaddr, 4 * i); end
      step();
      n_cmp++; if (b.instr !== w[i] || b.npc !== 32'(4 * (i + 1)) || b.ivalid !== 1'b1) begin
        n_bad++; $display("FAIL seq_out%0d: got %h/%h/%0b want %h/%h/1", i, b.instr, b.npc, b.ivalid, w[i], 4 * (i + 1));
      end
    end
    n_cmp++; if (b.imemaddr !== 32'd12 || b.fetch_cnt !== 16'd3) begin
      n_bad++; $display("FAIL seq_final: got addr=%h cnt=%0d want c/3", b.imemaddr, b.fetch_cnt);
    end
  endtask

  task automatic test_stall();
    do_reset();
    drive(1'b1, 32'h1000_0001, 1'b0, 1'b0, 3'd0, 1'b0); step();
    drive(1'b1, 32'h1000_0002, 1'b0, 1'b0, 3'd0, 1'b0); step();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h1000_0003, 1'b1, 1'b0, 3'd0, 1'b0);
      #1;
      n_cmp++; if (b.imemREN !== 1'b0) begin n_bad++; $display("FAIL stall_ren%0d: got %0b want 0", i, b.imemREN); end
      step();
      n_cmp++; if (b.instr !== 32'h1000_0002 || b.npc !== 32'd8 || b.imemaddr !== 32'd8 || b.ivalid !== 1'b1) begin
        n_bad++; $display("FAIL stall_hold%0d: got %h/%h/%h/%0b want 10000002/8/8/1", i, b.instr, b.npc, b.imemaddr, b.ivalid);
      end
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b0); step();
    n_cmp++; if (b.ivalid !== 1'b0 || b.imemaddr !== 32'd8) begin
      n_bad++; $display("FAIL stall_consume: got v=%0b addr=%h want 0/8", b.ivalid, b.imemaddr);
    end
    drive(1'b1, 32'h1000_0003, 1'b0, 1'b0, 3'd0, 1'b0); step();
    n_cmp++; if (b.instr !== 32'h1000_0003 || b.npc !== 32'd12 || b.fetch_cnt !== 16'd3) begin
      n_bad++; $display("FAIL stall_resume: got %h/%h/%0d want 10000003/c/3", b.instr, b.npc, b.fetch_cnt);
    end
  endtask

  task automatic test_jump();
    do_reset();
    drive(1'b1, 32'h2000_0001, 1'b0, 1'b0, 3'd0, 1'b0); step();
    b.jr_addr = 32'h4000_000C;
    drive(1'b0, 32'h0, 1'b0, 1'b1, 3'd3, 1'b0); step();
    n_cmp++; if (b.imemaddr !== 32'h4000_000C || b.ivalid !== 1'b0) begin
      n_bad++; $display("FAIL jr: got addr=%h v=%0b want 4000000c/0", b.imemaddr, b.ivalid);
    end
    drive(1'b1, 32'h2000_0002, 1'b0, 1'b0, 3'd0, 1'b0); step();
    n_cmp++; if (b.npc !== 32'h4000_0010) begin n_bad++; $display("FAIL jr_npc: got %h want 40000010", b.npc); end
    b.jump_addr = 26'h000_0100;
    drive(1'b1, 32'h2000_0003, 1'b0, 1'b1, 3'd2, 1'b0); step();
    n_cmp++; if (b.imemaddr !== 32'h4000_0400 || b.ivalid !== 1'b0 || b.fetch_cnt !== 16'd2) begin
      n_bad++; $display("FAIL jump: got addr=%h v=%0b cnt=%0d want 40000400/0/2", b.imemaddr, b.ivalid, b.fetch_cnt);
    end
    drive(1'b1, 32'h2000_0004, 1'b0, 1'b0, 3'd0, 1'b0); step();
    // Out-of-range pcsrc values fall through to sequential fetch.
    drive(1'b1, 32'h2000_0005, 1'b0, 1'b1, 3'd0, 1'b0); step();
    drive(1'b1, 32'h2000_0006, 1'b0, 1'b1, 3'd5, 1'b0); step();
    n_cmp++; if (b.instr !== 32'h2000_0006 || b.npc !== 32'h4000_040C || b.ivalid !== 1'b1) begin
      n_bad++; $display("FAIL pcsrc_ignored: got %h/%h/%0b want 20000006/4000040c/1", b.instr, b.npc, b.ivalid);
    end
  endtask

  task automatic test_branch_halt();
    do_reset();
    drive(1'b1, 32'h3000_0001, 1'b0, 1'b0, 3'd0, 1'b0); step();
    b.branch_addr = 32'h80;
    drive(1'b1, 32'h3000_0002, 1'b0, 1'b1, 3'd1, 1'b1); step();
    n_cmp++; if (b.imemREN !== 1'b0 || b.ivalid !== 1'b0 || b.imemaddr !== 32'd4 || b.fetch_cnt !== 16'd1) begin
      n_bad++; $display("FAIL halt_wins: got ren=%0b v=%0b addr=%h cnt=%0d want 0/0/4/1", b.imemREN, b.ivalid, b.imemaddr, b.fetch_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h3000_0003, 1'b0, 1'b1, 3'd1, 1'b0); step();
    end
    n_cmp++; if (b.imemREN !== 1'b0 || b.ivalid !== 1'b0 || b.imemaddr !== 32'd4 || b.fetch_cnt !== 16'd1) begin
      n_bad++; $display("FAIL halted_stays: got ren=%0b v=%0b addr=%h cnt=%0d want 0/0/4/1", b.imemREN, b.ivalid, b.imemaddr, b.fetch_cnt);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b0);
    @(negedge CLK);
    #1 nRST = 1'b0;
    #1;
    n_cmp++; if (b.imemREN !== 1'b1 || b.imemaddr !== 32'h0 || b.fetch_cnt !== 16'h0 || b.ivalid !== 1'b0) begin
      n_bad++; $display("FAIL async_reset: got ren=%0b addr=%h cnt=%0d v=%0b want 1/0/0/0", b.imemREN, b.imemaddr, b.fetch_cnt, b.ivalid);
    end
    #1 nRST = 1'b1;
    model_reset();
    drive(1'b1, 32'h4000_0001, 1'b0, 1'b0, 3'd0, 1'b0);
    step();
    n_cmp++; if (b.instr !== 32'h4000_0001 || b.npc !== 32'd4 || b.imemaddr !== 32'd4 || b.fetch_cnt !== 16'd1) begin
      n_bad++; $display("FAIL async_refetch: got %h/%h/%h/%0d want 40000001/4/4/1", b.instr, b.npc, b.imemaddr, b.fetch_cnt);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    n_cmp++; if (bw.imemaddr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_init: got %h want fffffffc", bw.imemaddr); end
    bw.ihit = 1'b1; bw.iload = 32'h5555_0001;
    @(posedge CLK);
    #1;
    n_cmp++; if (bw.npc !== 32'h0 || bw.imemaddr !== 32'h0 || bw.ivalid !== 1'b1) begin
      n_bad++; $display("FAIL pc_wrap: got npc=%h addr=%h v=%0b want 0/0/1", bw.npc, bw.imemaddr, bw.ivalid);
    end
    bw.ihit = 1'b0;
  endtask

  task automatic test_cnt_wrap();
    do_reset();
    for (int i = 0; i < 65535; i++) begin
      drive(1'b1, 32'(i), 1'b0, 1'b0, 3'd0, 1'b0);
      step();
    end
    n_cmp++; if (b.fetch_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL cnt_max: got %h want ffff", b.fetch_cnt); end
    drive(1'b1, 32'h0, 1'b0, 1'b0, 3'd0, 1'b0);
    step();
    n_cmp++; if (b.fetch_cnt !== 16'h0 || b.imemaddr !== 32'h0004_0000) begin
      n_bad++; $display("FAIL cnt_wrap: got cnt=%h addr=%h want 0/40000", b.fetch_cnt, b.imemaddr);
    end
  endtask

  task automatic test_random();
    logic exp_ren;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (m_halted && $urandom_range(0, 7) == 0) do_reset();
      drive(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), ($urandom_range(0, 31) == 0));
      b.branch_addr = $urandom; b.jump_addr = 26'($urandom); b.jr_addr = $urandom;
      #1;
      exp_ren = !m_halted && !(m_valid && b.stall);
      n_cmp++; if (b.imemREN !== exp_ren) begin n_bad++; $display("FAIL rnd_ren%0d: got %0b want %0b", i, b.imemREN, exp_ren); end
      step();
      n_cmp++;
      if ({b.imemaddr, b.instr, b.npc, b.ivalid, b.fetch_cnt} !==
          {m_pc & 32'hFFFF_FFFC, m_instr, m_npc, m_valid, m_cnt}) begin
        n_bad++;
        $display("FAIL rnd_state%0d: got addr=%h instr=%h npc=%h v=%0b cnt=%0d want %h/%h/%h/%0b/%0d",
                 i, b.imemaddr, b.instr, b.npc, b.ivalid, b.fetch_cnt,
                 m_pc & 32'hFFFF_FFFC, m_instr, m_npc, m_valid, m_cnt);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    nRST  = 1'b1;
    model_reset();
    zero_inputs();
    test_reset();
    test_sequential();
    test_stall();
    test_jump();
    test_branch_halt();
    test_async_reset();
    test_wrap();
    test_random();
    test_cnt_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
